// File: rtl/tx_fifo_rs232.sv
// Byte FIFO in front of a tx_rs232 transmitter: one send pulse per completed frame.
// Optional macro TX_FIFO_GAP_EN inserts GAP_CYC idle cycles after every frame.
module tx_fifo_rs232 #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int GAP_CYC = 16
) (
  input  logic        clk_s,
  input  logic        rst_s,
  input  logic [7:0]  iDATA,
  input  logic        iWR,
  output logic [7:0]  oTX_DATA,
  output logic        oTX_SEND,
  input  logic        iTX_FINISH,
  output logic        oFULL,
  output logic        oEMPTY,
  output logic [AW:0] oCOUNT,
  output logic        oOVF
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

`ifdef TX_FIFO_GAP_EN
  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  logic [GW-1:0] gap_q;
`else
  typedef enum logic {IDLE, WAIT} state_t;
  logic unused_gap;
  assign unused_gap = (GAP_CYC == 0);
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  state_t        state_q;
  logic [7:0]    data_q;
  logic          send_q, full_q, empty_q, ovf_q;
  logic          pop, wr_acc;

  // The pop decision uses only registered state, so a write is never forwarded in the same cycle.
  assign pop    = (state_q == IDLE) && (count_q != '0);
  assign wr_acc = iWR && (!full_q || pop);

  always_comb begin
    count_d = count_q;
    if (wr_acc && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !wr_acc)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_s) begin
    if (wr_acc && !rst_s)
      mem[wptr_q] <= iDATA;
  end

  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      send_q  <= 1'b0;
      data_q  <= 8'h00;
`ifdef TX_FIFO_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
      send_q  <= 1'b0;
      if (wr_acc)
        wptr_q <= wptr_q + 1'b1;
      if (iWR && !wr_acc)
        ovf_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            data_q  <= mem[rptr_q];
            rptr_q  <= rptr_q + 1'b1;
            send_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // A finish coinciding with our own send pulse belongs to an older frame.
          if (iTX_FINISH && !send_q) begin
`ifdef TX_FIFO_GAP_EN
            state_q <= GAP;
            gap_q   <= '0;
`else
            state_q <= IDLE;
`endif
          end
        end
`ifdef TX_FIFO_GAP_EN
        GAP: begin
          if (gap_q == GW'(GAP_CYC - 1)) begin
            state_q <= IDLE;
            gap_q   <= '0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oTX_DATA = data_q;
  assign oTX_SEND = send_q;
  assign oFULL    = full_q;
  assign oEMPTY   = empty_q;
  assign oCOUNT   = count_q;
  assign oOVF     = ovf_q;

endmodule

// File: tb/tb_tx_fifo_rs232.sv
// Self-checking bench for tx_fifo_rs232: queue-based reference model plus directed scenarios.
module tb_tx_fifo_rs232;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int GAP_CYC = 16;
`ifdef TX_FIFO_GAP_EN
  localparam int GAPV = GAP_CYC;
`else
  localparam int GAPV = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_s = 1'b1;
  logic [7:0]  iDATA = 8'h00;
  logic        iWR = 1'b0;
  logic        iTX_FINISH = 1'b0;
  logic [7:0]  oTX_DATA;
  logic        oTX_SEND;
  logic        oFULL, oEMPTY, oOVF;
  logic [AW:0] oCOUNT;

  tx_fifo_rs232 #(.DEPTH(DEPTH), .AW(AW), .GAP_CYC(GAP_CYC)) dut (
    .clk_s(clk), .rst_s(rst_s), .iDATA(iDATA), .iWR(iWR),
    .oTX_DATA(oTX_DATA), .oTX_SEND(oTX_SEND), .iTX_FINISH(iTX_FINISH),
    .oFULL(oFULL), .oEMPTY(oEMPTY), .oCOUNT(oCOUNT), .oOVF(oOVF)
  );

  always #5 clk = ~clk;

  // Reference: a byte queue, a "frame outstanding" flag and the earliest cycle the next pop may happen.
  byte unsigned m_q[$];
  int          now = 0, ready_at = 0, send_cyc = -1;
  bit          busy = 1'b0, m_send = 1'b0, m_ovf = 1'b0, mdl_ok = 1'b0, m_pop, m_fin;
  logic [7:0]  m_data = 8'h00;

  always @(posedge clk) begin
    if (rst_s) begin
      m_q.delete();
      busy = 1'b0; ready_at = 0; m_send = 1'b0; m_ovf = 1'b0; m_data = 8'h00; mdl_ok = 1'b1;
    end else begin
      m_pop  = !busy && (now >= ready_at) && (m_q.size() != 0);
      m_fin  = busy && iTX_FINISH && (now != send_cyc);
      m_send = 1'b0;
      if (m_pop) begin
        m_data = m_q.pop_front(); m_send = 1'b1; busy = 1'b1; send_cyc = now + 1;
      end else if (m_fin) begin
        busy = 1'b0; ready_at = now + 1 + GAPV;
      end
      if (iWR) begin
        if (m_q.size() < DEPTH) m_q.push_back(iDATA);
        else m_ovf = 1'b1;
      end
    end
    now++;
  end

  int         checks = 0, failures = 0, nsend = 0;
  logic [7:0] sent[$];
  bit         stub_busy = 1'b0, stub_hold = 1'b0, spur_en = 1'b0, rnd_lat = 1'b0;
  int         stub_cnt = 0, stub_lat = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: compare against the model, run the tx_rs232 stub, then drive this cycle's inputs.
  task automatic cyc(input bit wr = 1'b0, input logic [7:0] d = 8'h00,
                     input bit ff = 1'b0, input bit rst = 1'b0);
    bit fin;
    @(negedge clk);
    if (mdl_ok) begin
      chk("tx_send", int'(oTX_SEND), int'(m_send));
      chk("tx_data", int'(oTX_DATA), int'(m_data));
      chk("count",   int'(oCOUNT),   m_q.size());
      chk("full",    int'(oFULL),    int'(m_q.size() == DEPTH));
      chk("empty",   int'(oEMPTY),   int'(m_q.size() == 0));
      chk("ovf",     int'(oOVF),     int'(m_ovf));
    end
    if (oTX_SEND === 1'b1) begin
      nsend++;
      sent.push_back(oTX_DATA);
    end
    fin = 1'b0;
    if (stub_busy) begin
      if (stub_cnt > 0) stub_cnt--;
      else if (!stub_hold) begin fin = 1'b1; stub_busy = 1'b0; end
    end else if (spur_en && $urandom_range(7) == 0) begin
      fin = 1'b1;
    end
    if (oTX_SEND === 1'b1) begin
      stub_busy = 1'b1;
      stub_cnt  = rnd_lat ? int'($urandom_range(6)) : stub_lat;
    end
    iTX_FINISH = fin | ff;
    iWR        = wr;
    iDATA      = d;
    rst_s      = rst;
  endtask

  task automatic do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    int  base, k;
    bit  got, wr, rst;
    int  rate;

    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_count", int'(oCOUNT), 0);
    chk("rst_empty", int'(oEMPTY), 1);
    chk("rst_full",  int'(oFULL), 0);
    chk("rst_ovf",   int'(oOVF), 0);
    chk("rst_send",  int'(oTX_SEND), 0);
    chk("rst_data",  int'(oTX_DATA), 0);

    // Single byte: send two cycles after the write, queue empty again afterwards.
    cyc(1'b1, 8'hA5);
    cyc();
    cyc();
    chk("a5_send", int'(oTX_SEND), 1);
    chk("a5_data", int'(oTX_DATA), 'hA5);
    cyc();
    chk("a5_count", int'(oCOUNT), 0);
    repeat (10) cyc();

    // Three bytes while the transmitter is busy: delivered in order.
    stub_lat = 5;
    base = sent.size();
    cyc(1'b1, 8'h01); cyc(1'b1, 8'h02); cyc(1'b1, 8'h03);
    repeat (40) cyc();
    chk("seq_n", sent.size() - base, 3);
    for (int i = 0; i < 3 && base + i < sent.size(); i++)
      chk("seq_byte", int'(sent[base+i]), i + 1);

    // Overflow: transmitter stalled, DEPTH+2 bytes written after the first pop.
    stub_lat = 0; stub_hold = 1'b1;
    do_reset();
    base = sent.size();
    cyc(1'b1, 8'hC0);
    repeat (3) cyc();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 8'(8'h10 + i));
    cyc();
    chk("ovf_count", int'(oCOUNT), 16);
    chk("ovf_full",  int'(oFULL), 1);
    chk("ovf_flag",  int'(oOVF), 1);
    stub_hold = 1'b0;
    repeat (120) cyc();
    chk("ovf_delivered", sent.size() - base, 17);
    if (sent.size() - base == 17) begin
      chk("ovf_first", int'(sent[base]), 'hC0);
      for (int i = 0; i < 16; i++) chk("ovf_byte", int'(sent[base+1+i]), 'h10 + i);
    end
    chk("ovf_sticky", int'(oOVF), 1);

    // Full FIFO in IDLE with a same-cycle write: both happen, no overflow.
    stub_hold = 1'b1;
    do_reset();
    cyc(1'b1, 8'hD0);
    repeat (3) cyc();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i));
    cyc();
    chk("fill_full", int'(oFULL), 1);
    chk("fill_ovf",  int'(oOVF), 0);
    stub_hold = 1'b0;
    cyc();
    cyc(1'b1, 8'hEE);
    cyc();
    chk("popwr_send",  int'(oTX_SEND), 1);
    chk("popwr_data",  int'(oTX_DATA), 'h40);
    chk("popwr_count", int'(oCOUNT), 16);
    chk("popwr_ovf",   int'(oOVF), 0);
    repeat (120) cyc();

    // Reset in WAIT with five queued bytes; the old frame's finish must not trigger a send.
    stub_hold = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h60 + i));
    repeat (3) cyc();
    chk("q5_count", int'(oCOUNT), 5);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc();
    chk("rstw_count", int'(oCOUNT), 0);
    chk("rstw_empty", int'(oEMPTY), 1);
    base = sent.size();
    stub_hold = 1'b0;
    repeat (10) cyc();
    chk("rstw_nosend", sent.size() - base, 0);

    // A write during reset is discarded.
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    cyc();
    cyc();
    chk("rstwr_count", int'(oCOUNT), 0);

    // Finish-to-next-send spacing with a byte already waiting.
    stub_hold = 1'b1;
    do_reset();
    cyc(1'b1, 8'h81); cyc(1'b1, 8'h82);
    repeat (4) cyc();
    cyc(1'b0, 8'h00, 1'b1);
    k = 0; got = 1'b0;
    for (int i = 1; i <= GAPV + 10 && !got; i++) begin
      cyc();
      if (oTX_SEND === 1'b1) begin got = 1'b1; k = i; end
    end
    chk("fin_to_send", k, 2 + GAPV);
    chk("gap_data", int'(oTX_DATA), 'h82);
    stub_hold = 1'b0;
    repeat (60) cyc();

    // Randomized traffic: alternating heavy and light write load, random frame lengths,
    // stray finish pulses and occasional resets.
    rnd_lat = 1'b1; spur_en = 1'b1;
    do_reset();
    base = nsend;
    for (int i = 0; i < 4000; i++) begin
      rate = ((i / 400) % 2 == 0) ? 8 : 1;
      wr   = ($urandom_range(9) < rate);
      rst  = ($urandom_range(599) == 0);
      cyc(wr, 8'($urandom), 1'b0, rst);
    end
    spur_en = 1'b0;
    repeat (300) cyc();
    chk("rand_drained", int'(oEMPTY), 1);
    chk("rand_activity", int'(nsend - base > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
